clk_div_ctrl: RTL and testbench
===============================

// Module: clk_div_ctrl
// PURPOSE
//   Programmable CPU clock generator driven from raw_clk. Successor to the fixed-interval divider:
//   - adds async reset and a parametrised divider width
//   - adds RUN / STEP / HALT modes and a debounced single-step button
//   - adds a rising-edge strobe and a cycle counter for the debug display
//   Sits between the board oscillator and the CPU core; clk/pclk feed the pipeline.
// PARAMETERS
//   DIV_W    16      width of div input (half-period length in raw_clk cycles)
//   CNT_W    32      width of cycle_cnt
//   DEB_CYC  65536   raw_clk cycles manual_clk must be stable before a level change is accepted
// PORTS
//   raw_clk     in   1      board clock; every register here clocks on its posedge
//   rst         in   1      reset, asynchronous, active-high
//   mode        in   2      00 RUN, 01 STEP, 10 HALT, 11 treated as RUN
//   div         in   DIV_W  half-period in raw_clk cycles; 0 treated as 1
//   manual_clk  in   1      raw step button, asynchronous, active-high
//   clk         out  1      generated CPU clock (registered)
//   pclk        out  1      one raw_clk-cycle strobe, high in the cycle clk goes 0->1
//   cycle_cnt   out  CNT_W  number of clk rising edges since reset, wraps to 0
//   busy        out  1      1 while a STEP period is in progress
// BEHAVIOUR
//   Reset (async assert, sync release): clk=0, pclk=0, cycle_cnt=0, busy=0; ph_cnt=0;
//     div_sh=1; sync/debounce regs=0; state=IDLE.
//   Divider: div_sh (DIV_W) = div, or 1 if div==0; latched at reset release and at every clk toggle.
//     A div change mid-phase takes effect from the next phase; no glitch, no short phase.
//     Each raw_clk cycle while the divider is enabled: if ph_cnt+1 >= div_sh then
//       ph_cnt<=0, clk<=~clk; else ph_cnt<=ph_cnt+1.
//     Compare in DIV_W+1 bits so div=all-ones does not wrap.
//     Each clk phase therefore lasts exactly div_sh raw_clk cycles.
//   pclk: registered; 1 in exactly the raw_clk cycle whose edge sets clk 0->1, else 0.
//     cycle_cnt increments on that same edge; all-ones -> 0.
//   Button: 2-FF synchroniser, then debounce counter. A level is accepted only after
//     DEB_CYC consecutive equal samples. step_req = 1-cycle pulse on accepted 0->1.
//   FSM states:
//     IDLE: divider held (ph_cnt=0, clk=0).
//       mode RUN -> RUN.
//       mode STEP and step_req -> STEP_HI, busy<=1.
//     RUN: divider enabled.
//       mode != RUN is sampled only at the edge where clk toggles 1->0; the FSM then goes to IDLE.
//       A high phase is never truncated.
//     STEP_HI: divider enabled; on clk 1->0 -> STEP_LO.
//     STEP_LO: low phase of div_sh cycles counted; at its end go to IDLE, busy<=0.
//       clk stays 0: no second rising edge.
//   STEP produces exactly one clk period: first edge is rising (pclk=1), high div_sh, low div_sh.
//   step_req while busy=1, or while not in STEP mode, is dropped (not queued).
//   HALT: once in IDLE, clk stays 0 and pclk stays 0 indefinitely.
//   Mode change RUN->STEP mid-high-phase: high phase completes, then IDLE awaiting a press.
//   Reset mid-operation: all outputs return to reset values immediately (asynchronous).
// TESTING
//   RUN, div=4, 40 raw cycles after reset -> clk period 8; pclk pulses 5 cycles apart? No:
//     exactly every 8 cycles; cycle_cnt=5.
//   RUN, div=0 -> clk toggles every raw cycle (period 2); pclk high every 2nd cycle.
//   RUN div=3, change div to 6 mid-high-phase -> current phase still 3 cycles, next phases 6.
//   STEP, DEB_CYC=4, hold manual_clk 10 cycles -> exactly one period (high 3, low 3);
//     busy high 6 cycles; cycle_cnt +1. Glitch of 2 cycles -> no step.
//   STEP, 2nd press during busy -> ignored; cycle_cnt +1 total.
//   HALT asserted mid-high-phase -> phase completes; clk then 0 forever.
//   Assert rst mid-phase -> clk, pclk, cycle_cnt = 0 before the next raw_clk edge.
//   CNT_W=4, 16 RUN periods -> cycle_cnt wraps to 0.

Source files
------------

// File: rtl/clk_div_ctrl_if.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl_if
// Bundles the control inputs and the generated-clock outputs of clk_div_ctrl.
//   mode        2      00 RUN, 01 STEP, 10 HALT, 11 RUN
//   div         DIV_W  half-period in raw_clk cycles (0 behaves as 1)
//   manual_clk  1      raw step button, asynchronous
//   clk         1      generated CPU clock
//   pclk        1      one-cycle strobe on each clk rising edge
//   cycle_cnt   CNT_W  clk rising edges since reset (wrapping)
//   busy        1      single-step period in progress
// master: the controlling side; slave: the clock generator.
// ---------------------------------------------------------------------------
interface clk_div_ctrl_if #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 32
);
    logic [1:0]       mode;
    logic [DIV_W-1:0] div;
    logic             manual_clk;
    logic             clk;
    logic             pclk;
    logic [CNT_W-1:0] cycle_cnt;
    logic             busy;

    modport master (
        output mode, div, manual_clk,
        input  clk, pclk, cycle_cnt, busy
    );

    modport slave (
        input  mode, div, manual_clk,
        output clk, pclk, cycle_cnt, busy
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl
// Programmable CPU clock generator running from raw_clk, with RUN / STEP /
// HALT modes, a debounced single-step button, a rising-edge strobe and a
// rising-edge counter.
// Ports:
//   i_raw_clk  board clock, all registers use its rising edge
//   i_rst      asynchronous, active-high reset
//   bus        clk_div_ctrl_if.slave (mode, div, manual_clk in;
//              clk, pclk, cycle_cnt, busy out)
//
// state     | meaning
// S_IDLE    | divider held, clk=0; tracks div; waits for RUN or a step press
// S_RUN     | free-running divider; leaves only on a clk 1->0 edge
// S_STEP_HI | high phase of a single step
// S_STEP_LO | low phase of a single step; ends in IDLE without a new rise
// ---------------------------------------------------------------------------
module clk_div_ctrl #(
    parameter int DIV_W   = 16,
    parameter int CNT_W   = 32,
    parameter int DEB_CYC = 65536
) (
    input  logic                i_raw_clk,
    input  logic                i_rst,
    clk_div_ctrl_if.slave       bus
);
    localparam int              DEB_W    = $clog2(DEB_CYC + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STEP_HI,
        S_STEP_LO
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [DIV_W-1:0] r_ph_cnt, w_ph_cnt_nxt;
    logic [DIV_W-1:0] r_div_sh, w_div_sh_nxt;
    logic             r_clk, w_clk_nxt;
    logic             r_pclk, w_pclk_nxt;
    logic             r_busy, w_busy_nxt;
    logic [CNT_W-1:0] r_cyc_cnt, w_cyc_cnt_nxt;

    logic             r_sync1, r_sync2, r_deb_lvl, r_step_req;
    logic [DEB_W-1:0] r_deb_cnt;

    logic [DIV_W-1:0] w_div_eff;
    logic [DIV_W-1:0] w_ph_inc;
    logic             w_tc;
    logic             w_run_mode;
    logic             w_step_mode;

    assign w_div_eff   = (bus.div == '0) ? DIV_W'(1) : bus.div;
    assign w_ph_inc    = r_ph_cnt + DIV_W'(1);
    // One extra bit so an all-ones divider does not wrap the compare.
    assign w_tc        = ({1'b0, r_ph_cnt} + (DIV_W+1)'(1)) >= {1'b0, r_div_sh};
    assign w_run_mode  = (bus.mode == 2'b00) || (bus.mode == 2'b11);
    assign w_step_mode = (bus.mode == 2'b01);

    // Button: two-flop synchroniser, then a level is accepted after DEB_CYC
    // consecutive samples that differ from the currently accepted level.
    always_ff @(posedge i_raw_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_deb_lvl  <= 1'b0;
            r_deb_cnt  <= '0;
            r_step_req <= 1'b0;
        end else begin
            r_sync1    <= bus.manual_clk;
            r_sync2    <= r_sync1;
            r_step_req <= 1'b0;
            if (r_sync2 == r_deb_lvl) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt >= DEB_LAST) begin
                r_deb_cnt  <= '0;
                r_deb_lvl  <= r_sync2;
                r_step_req <= r_sync2;
            end else begin
                r_deb_cnt <= r_deb_cnt + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge i_raw_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_ph_cnt  <= '0;
            r_div_sh  <= DIV_W'(1);
            r_clk     <= 1'b0;
            r_pclk    <= 1'b0;
            r_busy    <= 1'b0;
            r_cyc_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ph_cnt  <= w_ph_cnt_nxt;
            r_div_sh  <= w_div_sh_nxt;
            r_clk     <= w_clk_nxt;
            r_pclk    <= w_pclk_nxt;
            r_busy    <= w_busy_nxt;
            r_cyc_cnt <= w_cyc_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ph_cnt_nxt  = r_ph_cnt;
        w_div_sh_nxt  = r_div_sh;
        w_clk_nxt     = r_clk;
        w_pclk_nxt    = 1'b0;
        w_busy_nxt    = r_busy;
        w_cyc_cnt_nxt = r_cyc_cnt;

        case (r_state)
            S_IDLE: begin
                // No phase in flight, so div_sh can follow div freely here;
                // the first phase after leaving IDLE uses the current div.
                w_ph_cnt_nxt = '0;
                w_clk_nxt    = 1'b0;
                w_div_sh_nxt = w_div_eff;
                if (w_run_mode) begin
                    w_state_nxt = S_RUN;
                end else if (w_step_mode && r_step_req) begin
                    // A step starts with a rising edge at once.
                    w_state_nxt   = S_STEP_HI;
                    w_clk_nxt     = 1'b1;
                    w_pclk_nxt    = 1'b1;
                    w_cyc_cnt_nxt = r_cyc_cnt + CNT_W'(1);
                    w_busy_nxt    = 1'b1;
                end
            end

            S_RUN: begin
                if (w_tc) begin
                    w_ph_cnt_nxt = '0;
                    w_clk_nxt    = ~r_clk;
                    w_div_sh_nxt = w_div_eff;
                    if (!r_clk) begin
                        w_pclk_nxt    = 1'b1;
                        w_cyc_cnt_nxt = r_cyc_cnt + CNT_W'(1);
                    end else if (!w_run_mode) begin
                        // Leaving only on a falling edge keeps the high
                        // phase whole.
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_ph_cnt_nxt = w_ph_inc;
                end
            end

            S_STEP_HI: begin
                if (w_tc) begin
                    w_ph_cnt_nxt = '0;
                    w_clk_nxt    = 1'b0;
                    w_div_sh_nxt = w_div_eff;
                    w_state_nxt  = S_STEP_LO;
                end else begin
                    w_ph_cnt_nxt = w_ph_inc;
                end
            end

            S_STEP_LO: begin
                if (w_tc) begin
                    w_ph_cnt_nxt = '0;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_ph_cnt_nxt = w_ph_inc;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.clk       = r_clk;
    assign bus.pclk      = r_pclk;
    assign bus.cycle_cnt = r_cyc_cnt;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_div_ctrl
// Self-checking bench for clk_div_ctrl (DIV_W=8, CNT_W=4, DEB_CYC=4).
// Expected waveforms come from closed-form arithmetic on the sample index
// after reset release, or from whole-run tallies for the step scenarios.
// ---------------------------------------------------------------------------
module tb_clk_div_ctrl;
    localparam int DIV_W   = 8;
    localparam int CNT_W   = 4;
    localparam int DEB_CYC = 4;

    logic raw_clk = 1'b0;
    logic rst     = 1'b1;

    int total = 0;
    int bad   = 0;

    clk_div_ctrl_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

    clk_div_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W), .DEB_CYC(DEB_CYC)) dut (
        .i_raw_clk (raw_clk),
        .i_rst     (rst),
        .bus       (bus)
    );

    always #5 raw_clk = ~raw_clk;

    // Reset with the given mode/div; returns at the negedge where rst drops.
    // The next posedge is the first edge the design sees (sample index 0).
    task automatic do_reset(input logic [1:0] m, input int d);
        @(negedge raw_clk);
        rst            = 1'b1;
        bus.mode       = m;
        bus.div        = DIV_W'(d);
        bus.manual_clk = 1'b0;
        repeat (2) @(negedge raw_clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.mode       = 2'b00;
        bus.div        = 8'd4;
        bus.manual_clk = 1'b0;
        #1;
        total++;
        if ({bus.clk, bus.pclk, bus.busy} !== 3'b000 || bus.cycle_cnt !== 4'd0) begin
            bad++;
            $display("FAIL reset_state clk/pclk/busy=%b%b%b cnt=%0d want 000 cnt=0",
                     bus.clk, bus.pclk, bus.busy, bus.cycle_cnt);
        end
    endtask

    // Free-running RUN: after sample n (d = effective half period),
    // clk = (n/d)%2, pclk at n%(2d)==d, rising edges so far = (n+d)/(2d).
    task automatic test_run_divider();
        int divs [5] = '{4, 0, 1, 255, 7};
        int lens [5] = '{40, 20, 40, 530, 50};
        for (int t = 0; t < 9; t++) begin
            int d_in, d, ncyc;
            logic [1:0] m;
            if (t < 5) begin
                d_in = divs[t];
                ncyc = lens[t];
                m    = 2'b00;
            end else begin
                d_in = int'($urandom_range(0, 12));
                ncyc = int'($urandom_range(30, 80));
                m    = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
            end
            d = (d_in == 0) ? 1 : d_in;
            do_reset(m, d_in);
            for (int n = 0; n < ncyc; n++) begin
                logic       e_clk, e_pclk;
                logic [3:0] e_cnt;
                @(negedge raw_clk);
                e_clk  = ((n / d) % 2) == 1;
                e_pclk = (n % (2 * d)) == d;
                e_cnt  = 4'(((n + d) / (2 * d)) % 16);
                total++;
                if (bus.clk !== e_clk || bus.pclk !== e_pclk || bus.cycle_cnt !== e_cnt) begin
                    bad++;
                    $display("FAIL run div=%0d n=%0d got clk=%b pclk=%b cnt=%0d want clk=%b pclk=%b cnt=%0d",
                             d_in, n, bus.clk, bus.pclk, bus.cycle_cnt, e_clk, e_pclk, e_cnt);
                end
            end
        end
    endtask

    // Change div during the first high phase: that phase keeps d1, all later
    // phases use d2.
    task automatic test_div_change();
        for (int t = 0; t < 3; t++) begin
            int d1, d2, k;
            if (t == 0) begin
                d1 = 3; d2 = 6; k = 0;
            end else begin
                d1 = int'($urandom_range(1, 5));
                d2 = int'($urandom_range(1, 8));
                k  = int'($urandom_range(0, d1 - 1));
            end
            do_reset(2'b00, d1);
            for (int n = 0; n < 2 * d1 + 4 * d2 + 2; n++) begin
                logic e_clk;
                @(negedge raw_clk);
                if (n < 2 * d1) e_clk = ((n / d1) % 2) == 1;
                else            e_clk = (((n - 2 * d1) / d2) % 2) == 1;
                total++;
                if (bus.clk !== e_clk) begin
                    bad++;
                    $display("FAIL div_change d1=%0d d2=%0d n=%0d got clk=%b want %b",
                             d1, d2, n, bus.clk, e_clk);
                end
                if (n == d1 + k) bus.div = DIV_W'(d2);
            end
        end
    endtask

    // One press held 10 cycles: exactly one period, high d then low d,
    // busy for 2d cycles starting with the rise.
    task automatic test_step();
        for (int t = 0; t < 3; t++) begin
            int d, rise, hi, last_hi, bsy, b_first, b_last, np;
            d = (t == 0) ? 3 : int'($urandom_range(1, 6));
            rise = -1; hi = 0; last_hi = -1; bsy = 0; b_first = -1; b_last = -1; np = 0;
            do_reset(2'b01, d);
            for (int n = 0; n < 60; n++) begin
                bus.manual_clk = (n < 10);
                @(negedge raw_clk);
                if (bus.pclk === 1'b1) begin
                    np++;
                    if (rise < 0) rise = n;
                end
                if (bus.clk === 1'b1) begin
                    hi++;
                    last_hi = n;
                end
                if (bus.busy === 1'b1) begin
                    bsy++;
                    if (b_first < 0) b_first = n;
                    b_last = n;
                end
            end
            total++;
            if (np != 1) begin
                bad++;
                $display("FAIL step_pulses d=%0d got %0d want 1", d, np);
            end
            total++;
            if (hi != d || last_hi - rise + 1 != d) begin
                bad++;
                $display("FAIL step_high d=%0d got hi=%0d span=%0d want %0d", d, hi, last_hi - rise + 1, d);
            end
            total++;
            if (bsy != 2 * d || b_first != rise || b_last - b_first + 1 != 2 * d) begin
                bad++;
                $display("FAIL step_busy d=%0d got cycles=%0d start=%0d want cycles=%0d start=%0d",
                         d, bsy, b_first, 2 * d, rise);
            end
            total++;
            if (bus.cycle_cnt !== 4'd1 || bus.clk !== 1'b0) begin
                bad++;
                $display("FAIL step_end d=%0d got cnt=%0d clk=%b want cnt=1 clk=0", d, bus.cycle_cnt, bus.clk);
            end
        end
    endtask

    task automatic test_glitch();
        int np, bsy;
        np = 0; bsy = 0;
        do_reset(2'b01, 3);
        for (int n = 0; n < 40; n++) begin
            bus.manual_clk = (n >= 2 && n < 4);
            @(negedge raw_clk);
            if (bus.pclk === 1'b1) np++;
            if (bus.busy === 1'b1) bsy++;
        end
        total++;
        if (np != 0 || bsy != 0 || bus.cycle_cnt !== 4'd0) begin
            bad++;
            $display("FAIL glitch got pulses=%0d busy=%0d cnt=%0d want 0 0 0", np, bsy, bus.cycle_cnt);
        end
    endtask

    // Second press lands while busy and is dropped; a third press after the
    // step has finished gives a second step.
    task automatic test_back_to_back();
        int np_early, np_all;
        np_early = 0; np_all = 0;
        do_reset(2'b01, 12);
        for (int n = 0; n < 100; n++) begin
            bus.manual_clk = (n < 10) || (n >= 18 && n < 26) || (n >= 40 && n < 48);
            @(negedge raw_clk);
            if (bus.pclk === 1'b1) begin
                np_all++;
                if (n < 40) np_early++;
            end
            if (n == 39) begin
                total++;
                if (bus.cycle_cnt !== 4'd1) begin
                    bad++;
                    $display("FAIL busy_press_cnt got %0d want 1", bus.cycle_cnt);
                end
            end
        end
        total++;
        if (np_early != 1) begin
            bad++;
            $display("FAIL busy_press_dropped got pulses=%0d want 1", np_early);
        end
        total++;
        if (np_all != 2 || bus.cycle_cnt !== 4'd2 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL press_after_busy got pulses=%0d cnt=%0d busy=%b want 2 2 0",
                     np_all, bus.cycle_cnt, bus.busy);
        end
    endtask

    // Leaving RUN during the first high phase: the phase completes, then clk
    // stays low with no further strobes.
    task automatic test_halt();
        for (int t = 0; t < 4; t++) begin
            int d, k;
            logic [1:0] m;
            d = int'($urandom_range(2, 5));
            k = int'($urandom_range(0, d - 1));
            m = (t % 2 == 0) ? 2'b10 : 2'b01;
            do_reset(2'b00, d);
            for (int n = 0; n < 2 * d + 40; n++) begin
                logic e_clk, e_pclk;
                @(negedge raw_clk);
                e_clk  = (n >= d) && (n < 2 * d);
                e_pclk = (n == d);
                total++;
                if (bus.clk !== e_clk || bus.pclk !== e_pclk) begin
                    bad++;
                    $display("FAIL halt mode=%b d=%0d n=%0d got clk=%b pclk=%b want clk=%b pclk=%b",
                             m, d, n, bus.clk, bus.pclk, e_clk, e_pclk);
                end
                if (n == d + k) bus.mode = m;
            end
            total++;
            if (bus.cycle_cnt !== 4'd1) begin
                bad++;
                $display("FAIL halt_cnt got %0d want 1", bus.cycle_cnt);
            end
        end
    endtask

    // 16 rising edges with div=1 land at sample 31; the 4-bit count wraps.
    task automatic test_wrap();
        do_reset(2'b00, 1);
        for (int n = 0; n < 32; n++) begin
            @(negedge raw_clk);
            if (n == 29) begin
                total++;
                if (bus.cycle_cnt !== 4'd15) begin
                    bad++;
                    $display("FAIL wrap_pre got %0d want 15", bus.cycle_cnt);
                end
            end
        end
        total++;
        if (bus.cycle_cnt !== 4'd0 || bus.pclk !== 1'b1) begin
            bad++;
            $display("FAIL wrap got cnt=%0d pclk=%b want cnt=0 pclk=1", bus.cycle_cnt, bus.pclk);
        end
    endtask

    // Reset raised between edges must clear outputs before the next edge.
    task automatic test_reset_mid();
        int w;
        do_reset(2'b00, 3);
        w = int'($urandom_range(10, 25));
        repeat (w) @(negedge raw_clk);
        @(posedge raw_clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({bus.clk, bus.pclk, bus.busy} !== 3'b000 || bus.cycle_cnt !== 4'd0) begin
            bad++;
            $display("FAIL reset_mid got clk=%b pclk=%b busy=%b cnt=%0d want all 0",
                     bus.clk, bus.pclk, bus.busy, bus.cycle_cnt);
        end
        @(negedge raw_clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run_divider();
        test_div_change();
        test_step();
        test_glitch();
        test_back_to_back();
        test_halt();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
